// File: rtl/traffic_pkg.sv
// Shared encodings and default timing for the pedestrian crossing scheduler.
// Lights are one-hot {red,yellow,green} and {walk,dont_walk}.
package traffic_pkg;

  typedef enum logic [2:0] {
    V_GREEN,
    V_YELLOW,
    ALLRED_1,
    P_WALK,
    P_FLASH,
    ALLRED_2
  } state_t;

  localparam logic [2:0] VL_RED = 3'b100;
  localparam logic [2:0] VL_YEL = 3'b010;
  localparam logic [2:0] VL_GRN = 3'b001;

  localparam logic [1:0] PL_WALK = 2'b10;
  localparam logic [1:0] PL_DONT = 2'b01;

  localparam int DEF_TICK_DIV    = 12000000;
  localparam int DEF_GREEN_MIN_S = 10;
  localparam int DEF_YELLOW_S    = 2;
  localparam int DEF_ALLRED_S    = 1;
  localparam int DEF_WALK_S      = 6;
  localparam int DEF_FLASH_S     = 4;
  localparam int DEF_DEB_CYCLES  = 240000;

  function automatic logic [3:0] clamp9(input logic [4:0] v);
    return (v > 5'd9) ? 4'd9 : v[3:0];
  endfunction

endpackage

// File: rtl/ped_conditioner.sv
// Button synchroniser, optional debounce (PED_DEBOUNCE_EN) and rising-edge
// detector; press is a one-cycle pulse per accepted button press.
module ped_conditioner #(
  parameter int DEB_CYCLES = 240000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  logic sync1;
  logic sync2;
  logic level;
  logic level_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_d <= level;
    end
  end

`ifdef PED_DEBOUNCE_EN
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [CW-1:0] deb_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level   <= 1'b0;
      deb_cnt <= '0;
    end else if (sync2 == level) begin
      deb_cnt <= '0;
    end else if (deb_cnt == CW'(DEB_CYCLES - 1)) begin
      level   <= sync2;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end
`else
  // DEB_CYCLES only shapes the debounced build
  assign level = sync2 | (DEB_CYCLES < 0);
`endif

  assign press = level & ~level_d;

endmodule

// File: rtl/crossing_scheduler.sv
// Pedestrian crossing light sequencer driven by a 1 s tick.
// Define PED_DEBOUNCE_EN to debounce the pedestrian button.
module crossing_scheduler
  import traffic_pkg::*;
#(
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int GREEN_MIN_S = DEF_GREEN_MIN_S,
  parameter int YELLOW_S    = DEF_YELLOW_S,
  parameter int ALLRED_S    = DEF_ALLRED_S,
  parameter int WALK_S      = DEF_WALK_S,
  parameter int FLASH_S     = DEF_FLASH_S,
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pedestrian_btn,
  output logic [2:0] vehicle_light,
  output logic [1:0] pedestrian_light,
  output logic [3:0] countdown,
  output logic       req_pending,
  output logic       tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [3:0] GRN_T = 4'(GREEN_MIN_S);
  localparam logic [3:0] YEL_T = 4'(YELLOW_S);
  localparam logic [3:0] AR_T  = 4'(ALLRED_S);
  localparam logic [3:0] WLK_T = 4'(WALK_S);
  localparam logic [3:0] FLS_T = 4'(FLASH_S);

  logic [PW-1:0] pre_cnt;
  state_t        state;
  state_t        state_nx;
  logic [3:0]    timer;
  logic [3:0]    timer_nx;
  logic          req_nx;
  logic          press;
  logic          last;
  logic          flash_dont;

  ped_conditioner #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_ped (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (pedestrian_btn),
    .press(press)
  );

  assign tick = (pre_cnt == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= V_GREEN;
      timer       <= GRN_T;
      req_pending <= 1'b0;
    end else begin
      state       <= state_nx;
      timer       <= timer_nx;
      req_pending <= req_nx;
    end
  end

  assign last = (timer == 4'd1);

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    if (tick) begin
      timer_nx = (timer == 4'd0) ? 4'd0 : timer - 4'd1;
      unique case (state)
        V_GREEN:
          if (req_pending && timer <= 4'd1) begin
            state_nx = V_YELLOW;
            timer_nx = YEL_T;
          end
        V_YELLOW:
          if (last) begin
            state_nx = ALLRED_1;
            timer_nx = AR_T;
          end
        ALLRED_1:
          if (last) begin
            state_nx = P_WALK;
            timer_nx = WLK_T;
          end
        P_WALK:
          if (last) begin
            state_nx = P_FLASH;
            timer_nx = FLS_T;
          end
        P_FLASH:
          if (last) begin
            state_nx = ALLRED_2;
            timer_nx = AR_T;
          end
        ALLRED_2:
          if (last) begin
            state_nx = V_GREEN;
            timer_nx = GRN_T;
          end
        default: begin
          state_nx = V_GREEN;
          timer_nx = GRN_T;
        end
      endcase
    end
  end

  // walk entry clears the request and beats a press in the same cycle
  always_comb begin
    req_nx = req_pending;
    if (press && state != P_WALK) req_nx = 1'b1;
    if (state_nx == P_WALK && state != P_WALK) req_nx = 1'b0;
  end

  assign flash_dont = ~(timer[0] ^ FLS_T[0]);

  always_comb begin
    vehicle_light    = VL_RED;
    pedestrian_light = PL_DONT;
    countdown        = 4'd0;
    unique case (state)
      V_GREEN:  vehicle_light = VL_GRN;
      V_YELLOW: vehicle_light = VL_YEL;
      P_WALK: begin
        pedestrian_light = PL_WALK;
        countdown        = clamp9(5'(timer) + 5'(FLS_T));
      end
      P_FLASH: begin
        pedestrian_light = {1'b0, flash_dont};
        countdown        = clamp9({1'b0, timer});
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_crossing_scheduler.sv
// Directed bench for crossing_scheduler with TICK_DIV=4, DEB_CYCLES=3.
// Inputs change on negedges; samples are taken on negedges.
module tb_crossing_scheduler;

  localparam int TDIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn = 1'b0;
  logic [2:0] vehicle_light;
  logic [1:0] pedestrian_light;
  logic [3:0] countdown;
  logic       req_pending;
  logic       tick;

  int errors = 0;
  int checks = 0;

`ifdef PED_DEBOUNCE_EN
  localparam logic GLITCH_REQ = 1'b0;
`else
  localparam logic GLITCH_REQ = 1'b1;
`endif

  crossing_scheduler #(
    .TICK_DIV  (TDIV),
    .DEB_CYCLES(3)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pedestrian_btn  (btn),
    .vehicle_light   (vehicle_light),
    .pedestrian_light(pedestrian_light),
    .countdown       (countdown),
    .req_pending     (req_pending),
    .tick            (tick)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    btn   = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic adv(input int n);
    repeat (n * TDIV) @(negedge clk);
  endtask

  task automatic test_reset();
    logic exp_tick;
    btn   = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({vehicle_light, pedestrian_light, countdown, req_pending, tick}
        !== {3'b001, 2'b01, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got=%b %b %0d %b %b exp=001 01 0 0 0",
               vehicle_light, pedestrian_light, countdown, req_pending, tick);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      exp_tick = ((c % TDIV) == TDIV - 1);
      checks++;
      if (tick !== exp_tick) begin
        errors++;
        $display("FAIL tick_cycle%0d got=%b exp=%b", c, tick, exp_tick);
      end
    end
    checks++;
    if (vehicle_light !== 3'b001) begin
      errors++;
      $display("FAIL reset_green got=%b exp=001", vehicle_light);
    end
  endtask

  task automatic test_idle();
    do_reset();
    for (int t = 1; t <= 100; t++) begin
      adv(1);
      checks++;
      if ({vehicle_light, pedestrian_light, countdown} !== {3'b001, 2'b01, 4'd0}) begin
        errors++;
        $display("FAIL idle_tick%0d got=%b %b %0d exp=001 01 0",
                 t, vehicle_light, pedestrian_light, countdown);
      end
    end
  endtask

  task automatic test_walk_cycle();
    logic [9:0] exp_tab [12];
    exp_tab = '{
      {3'b100, 2'b10, 4'd9, 1'b0},
      {3'b100, 2'b10, 4'd9, 1'b0},
      {3'b100, 2'b10, 4'd8, 1'b0},
      {3'b100, 2'b10, 4'd7, 1'b0},
      {3'b100, 2'b10, 4'd6, 1'b0},
      {3'b100, 2'b10, 4'd5, 1'b0},
      {3'b100, 2'b01, 4'd4, 1'b0},
      {3'b100, 2'b00, 4'd3, 1'b0},
      {3'b100, 2'b01, 4'd2, 1'b0},
      {3'b100, 2'b00, 4'd1, 1'b0},
      {3'b100, 2'b01, 4'd0, 1'b0},
      {3'b001, 2'b01, 4'd0, 1'b0}
    };
    do_reset();
    adv(2);
    btn = 1'b1;
    adv(7);
    checks++;
    if ({vehicle_light, req_pending} !== {3'b001, 1'b1}) begin
      errors++;
      $display("FAIL walk_t9 got=%b %b exp=001 1", vehicle_light, req_pending);
    end
    adv(1);
    checks++;
    if (vehicle_light !== 3'b010) begin
      errors++;
      $display("FAIL walk_yellow_t10 got=%b exp=010", vehicle_light);
    end
    adv(2);
    checks++;
    if ({vehicle_light, pedestrian_light} !== {3'b100, 2'b01}) begin
      errors++;
      $display("FAIL walk_allred_t12 got=%b %b exp=100 01",
               vehicle_light, pedestrian_light);
    end
    for (int t = 13; t <= 24; t++) begin
      adv(1);
      checks++;
      if ({vehicle_light, pedestrian_light, countdown, req_pending}
          !== exp_tab[t-13]) begin
        errors++;
        $display("FAIL walk_seq_t%0d got=%b exp=%b", t,
                 {vehicle_light, pedestrian_light, countdown, req_pending},
                 exp_tab[t-13]);
      end
      if (t == 15) btn = 1'b0;
    end
    adv(10);
    checks++;
    if ({vehicle_light, req_pending} !== {3'b001, 1'b0}) begin
      errors++;
      $display("FAIL held_once_t34 got=%b %b exp=001 0", vehicle_light, req_pending);
    end
  endtask

  task automatic test_late_press();
    do_reset();
    adv(29);
    @(negedge clk);
    btn = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (vehicle_light !== 3'b001) begin
      errors++;
      $display("FAIL late_t30 got=%b exp=001", vehicle_light);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({vehicle_light, req_pending} !== {3'b001, 1'b1}) begin
      errors++;
      $display("FAIL late_req got=%b %b exp=001 1", vehicle_light, req_pending);
    end
    @(negedge clk);
    checks++;
    if (vehicle_light !== 3'b010) begin
      errors++;
      $display("FAIL late_yellow_t31 got=%b exp=010", vehicle_light);
    end
    btn = 1'b0;
  endtask

  task automatic test_walk_flash_press();
    do_reset();
    adv(2);
    btn = 1'b1;
    adv(2);
    btn = 1'b0;
    adv(10);
    btn = 1'b1;
    adv(2);
    checks++;
    if ({pedestrian_light, req_pending} !== {2'b10, 1'b0}) begin
      errors++;
      $display("FAIL walk_press_t16 got=%b %b exp=10 0", pedestrian_light, req_pending);
    end
    btn = 1'b0;
    adv(3);
    checks++;
    if ({pedestrian_light, req_pending} !== {2'b01, 1'b0}) begin
      errors++;
      $display("FAIL flash_entry_t19 got=%b %b exp=01 0", pedestrian_light, req_pending);
    end
    btn = 1'b1;
    adv(2);
    checks++;
    if (req_pending !== 1'b1) begin
      errors++;
      $display("FAIL flash_press_t21 got=%b exp=1", req_pending);
    end
    btn = 1'b0;
    adv(3);
    checks++;
    if ({vehicle_light, req_pending} !== {3'b001, 1'b1}) begin
      errors++;
      $display("FAIL flash_green_t24 got=%b %b exp=001 1", vehicle_light, req_pending);
    end
    adv(9);
    checks++;
    if (vehicle_light !== 3'b001) begin
      errors++;
      $display("FAIL flash_green_t33 got=%b exp=001", vehicle_light);
    end
    adv(1);
    checks++;
    if (vehicle_light !== 3'b010) begin
      errors++;
      $display("FAIL flash_yellow_t34 got=%b exp=010", vehicle_light);
    end
  endtask

  task automatic test_reset_mid_walk();
    do_reset();
    adv(2);
    btn = 1'b1;
    adv(2);
    btn = 1'b0;
    adv(11);
    checks++;
    if ({vehicle_light, pedestrian_light} !== {3'b100, 2'b10}) begin
      errors++;
      $display("FAIL pre_abort_t15 got=%b %b exp=100 10", vehicle_light, pedestrian_light);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({vehicle_light, pedestrian_light, countdown, req_pending, tick}
        !== {3'b001, 2'b01, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort_async got=%b %b %0d %b %b exp=001 01 0 0 0",
               vehicle_light, pedestrian_light, countdown, req_pending, tick);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    adv(1);
    checks++;
    if ({vehicle_light, pedestrian_light, req_pending} !== {3'b001, 2'b01, 1'b0}) begin
      errors++;
      $display("FAIL abort_after got=%b %b %b exp=001 01 0",
               vehicle_light, pedestrian_light, req_pending);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    adv(1);
    btn = 1'b1;
    repeat (2) @(negedge clk);
    btn = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (req_pending !== GLITCH_REQ) begin
      errors++;
      $display("FAIL glitch_req got=%b exp=%b", req_pending, GLITCH_REQ);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_walk_cycle();
    test_late_press();
    test_walk_flash_press();
    test_reset_mid_walk();
    test_glitch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/crossing_scheduler.md
CROSSING_SCHEDULER -- requirements
Module: crossing_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 12000000, meaning clk cycles per 1 s tick.
REQ-002 SHALL have parameter GREEN_MIN_S, default 10, meaning minimum vehicle green in ticks.
REQ-003 SHALL have parameters YELLOW_S=2, ALLRED_S=1, WALK_S=6, FLASH_S=4, each a phase length in ticks, each 1..15.
REQ-004 SHALL have parameter DEB_CYCLES, default 240000, meaning button-stable cycles (20 ms at 12 MHz).
REQ-005 SHALL have port clk  input  1  system clock, 12 MHz.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port pedestrian_btn  input  1  raw, asynchronous, active-high button.
REQ-008 SHALL have port vehicle_light  output  3  {red,yellow,green}, one-hot.
REQ-009 SHALL have port pedestrian_light  output  2  {walk,dont_walk}.
REQ-010 SHALL have port countdown  output  4  crossing seconds remaining, BCD digit 0..9.
REQ-011 SHALL have port req_pending  output  1  latched pedestrian request.
REQ-012 SHALL have port tick  output  1  one-cycle 1 s strobe.

Function
REQ-013 SHALL generate tick from a counter running 0..TICK_DIV-1, asserting tick for one cycle when the counter equals TICK_DIV-1, then wrapping to 0.
REQ-014 SHALL implement states V_GREEN, V_YELLOW, ALLRED_1, P_WALK, P_FLASH, ALLRED_2, advancing only on tick cycles.
REQ-015 SHALL load a 4-bit timer with the phase length on state entry and decrement it on each tick, so each timed phase lasts exactly its length in ticks.
REQ-016 SHALL leave V_GREEN on the tick where timer==1 if req_pending=1; otherwise hold timer at 0 and leave on the first tick with req_pending=1.
REQ-017 SHALL sequence V_YELLOW->ALLRED_1->P_WALK->P_FLASH->ALLRED_2->V_GREEN, each on the tick where timer==1.
REQ-018 SHALL drive vehicle_light 001 in V_GREEN, 010 in V_YELLOW, and 100 in all other states.
REQ-019 SHALL drive pedestrian_light 10 in P_WALK and 01 in all other states, except in P_FLASH, where walk=0 and dont_walk toggles on each tick starting at 1.
REQ-020 SHALL drive countdown with the remaining P_WALK+P_FLASH ticks, clamped to 9, in P_WALK/P_FLASH, and 0 elsewhere.
REQ-021 SHALL set req_pending on a conditioned rising edge of pedestrian_btn in any state except P_WALK.
REQ-022 SHALL ignore presses during P_WALK; SHALL latch presses in P_FLASH/ALLRED_2 for the next cycle.
REQ-023 SHALL clear req_pending on entry to P_WALK; clear SHALL win over a simultaneous set.
REQ-024 SHALL treat a held button as one request; a further request needs release and re-press.
REQ-025 SHALL synchronise pedestrian_btn through two flops before any use.

Reset
REQ-026 SHALL, while rst_n=0, force: state V_GREEN, timer GREEN_MIN_S, prescaler 0, tick 0, req_pending 0, vehicle_light 001, pedestrian_light 01, countdown 0, debounce and sync flops 0.
REQ-027 SHALL abort any phase, including P_WALK, on reset assertion; after release, the first tick SHALL occur TICK_DIV cycles later.

Configuration
REQ-028 SHALL, with PED_DEBOUNCE_EN defined, accept a synchronised button level only after DEB_CYCLES consecutive equal samples.
REQ-029 SHALL, without PED_DEBOUNCE_EN, edge-detect the two-flop synchronised level directly, with no debounce counter synthesised.

Structure
REQ-030 SHALL place state encoding, light encodings (VL_RED/VL_YEL/VL_GRN, PL_WALK/PL_DONT) and default phase lengths in shared package traffic_pkg.
REQ-031 SHALL implement synchroniser, debounce and rising-edge detection in sub-module ped_conditioner, whose output is a one-cycle press pulse.

Verification (TICK_DIV=4, DEB_CYCLES=3)
REQ-032 SHALL verify: no press, 100 ticks -> vehicle_light stays 001, pedestrian_light stays 01.
REQ-033 SHALL verify: press at tick 2 after reset -> V_YELLOW entered at tick 10, P_WALK at tick 13 with req_pending=0, countdown 9,9,8..1 then 0 in ALLRED_2, V_GREEN at tick 24.
REQ-034 SHALL verify: press at tick 30 (green timer already 0) -> V_YELLOW on the next tick.
REQ-035 SHALL verify: press during P_WALK -> req_pending stays 0; press during P_FLASH -> req_pending=1 and V_YELLOW exactly GREEN_MIN_S ticks after the return to V_GREEN.
REQ-036 SHALL verify: rst_n low for 2 cycles mid-P_WALK -> outputs 001/01 within the same cycle, req_pending 0.
REQ-037 SHALL verify: 2-cycle glitch pulses -> with PED_DEBOUNCE_EN, no request; without it, req_pending=1.
